// File: rtl/bcd_pkg.sv
// Shared BCD types: digit typedef, largest legal digit value and subtractor FSM states.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Operand/result bundle for the serial BCD subtractor; slave = subtractor, master = requester.
interface bcd_serial_subtractor_if #(
    parameter int DIGITS = 4
) ();

    logic                  start;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  bin;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   Diff;
    logic                  bout;
    logic                  err;

    modport master (
        output start, A, B, bin,
        input  ready, done, Diff, bout, err
    );

    modport slave (
        input  start, A, B, bin,
        output ready, done, Diff, bout, err
    );

endinterface

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtract with borrow: d = a - b - br_in, wrapped by +10 when negative.
// Purely combinational; no state, no backpressure.
import bcd_pkg::*;

module bcd_digit_sub (
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       br_in,
    output bcd_digit_t d,
    output logic       br_out
);

    logic [4:0] t;

    // 5-bit two's complement covers -16..15, so bit 4 is the sign even for illegal digits
    always_comb begin
        t      = {1'b0, a} - {1'b0, b} - {4'b0000, br_in};
        br_out = t[4];
        d      = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Serial packed-BCD subtractor, one digit per cycle LSD first; err check under BCD_SUB_ERR_CHECK_EN.
// Latency DIGITS+1 cycles from accepted start to the done pulse.
// ready is low only while running; start is ignored then.
import bcd_pkg::*;

module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bcd_serial_subtractor_if.slave   io
);

    localparam int             W    = 4 * DIGITS;
    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            br_q,    br_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [W-1:0]    acc_q,   acc_d;
    logic [W-1:0]    diff_q,  diff_d;
    logic            bout_q,  bout_d;

    logic            capture;
    bcd_digit_t      a_dig, b_dig, d_dig;
    logic            br_out;

    assign capture = (state_q != RUN) && io.start;
    assign a_dig   = a_q[{idx_q, 2'b00} +: 4];
    assign b_dig   = b_q[{idx_q, 2'b00} +: 4];

    bcd_digit_sub u_digit (
        .a      (a_dig),
        .b      (b_dig),
        .br_in  (br_q),
        .d      (d_dig),
        .br_out (br_out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        br_d    = br_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        if (capture) begin
            state_d = RUN;
            idx_d   = '0;
            br_d    = io.bin;
            a_d     = io.A;
            b_d     = io.B;
            acc_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    acc_d[{idx_q, 2'b00} +: 4] = d_dig;
                    br_d                       = br_out;
                    if (idx_q == LAST) begin
                        // Publish only on completion so Diff never shows a partial result
                        state_d = DONE;
                        diff_d  = acc_d;
                        bout_d  = br_out;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            br_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

`ifdef BCD_SUB_ERR_CHECK_EN
    logic bad_digit;
    logic err_q, err_d;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((io.A[4*i +: 4] > BCD_MAX) || (io.B[4*i +: 4] > BCD_MAX)) begin
                bad_digit = 1'b1;
            end
        end
        err_d = capture ? bad_digit : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign io.err = err_q;
`else
    assign io.err = 1'b0;
`endif

    assign io.ready = (state_q != RUN);
    assign io.done  = (state_q == DONE);
    assign io.Diff  = diff_q;
    assign io.bout  = bout_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4) with hand-computed expected results.
module tb_bcd_serial_subtractor;

    localparam int DIGITS = 4;

`ifdef BCD_SUB_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    bcd_serial_subtractor_if #(.DIGITS(DIGITS)) io ();

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issues one start, optionally pokes a second start at negedge inj, then watches 10 cycles.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [15:0] ediff, input logic ebout,
                          input logic eerr, input int inj);
        int first;
        int npulse;
        @(negedge clk);
        io.A = a; io.B = b; io.bin = bi; io.start = 1'b1;
        @(posedge clk);
        #1 io.start = 1'b0;
        first  = 0;
        npulse = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "_ready_in_run"}, {31'b0, io.ready}, 32'd0);
                chk({tag, "_err_in_run"}, {31'b0, io.err}, {31'b0, eerr});
            end
            if (inj > 0 && k == inj) begin
                io.A = 16'h5555; io.start = 1'b1;
            end
            if (inj > 0 && k == inj + 1) io.start = 1'b0;
            if (io.done) begin
                npulse++;
                if (first == 0) begin
                    first = k;
                    chk({tag, "_diff"}, {16'b0, io.Diff}, {16'b0, ediff});
                    chk({tag, "_bout"}, {31'b0, io.bout}, {31'b0, ebout});
                    chk({tag, "_err_at_done"}, {31'b0, io.err}, {31'b0, eerr});
                end
            end
        end
        chk({tag, "_latency"}, first, DIGITS + 1);
        chk({tag, "_done_pulses"}, npulse, 1);
        chk({tag, "_diff_held"}, {16'b0, io.Diff}, {16'b0, ediff});
        chk({tag, "_ready_after"}, {31'b0, io.ready}, 32'd1);
    endtask

    initial begin
        int npulse;
        io.start = 1'b0; io.A = '0; io.B = '0; io.bin = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'b0, io.ready}, 32'd1);
        chk("rst_done",  {31'b0, io.done},  32'd0);
        chk("rst_diff",  {16'b0, io.Diff},  32'd0);
        chk("rst_bout",  {31'b0, io.bout},  32'd0);
        chk("rst_err",   {31'b0, io.err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub_42_17",    16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 0);
        run_op("sub_0_1",      16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 0);
        run_op("sub_1000_1_b", 16'h1000, 16'h0001, 1'b1, 16'h0998, 1'b0, 1'b0, 0);
        run_op("ignore_start", 16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 2);
        run_op("sub_1234_567", 16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 0);

        // Abort mid-RUN: Diff currently holds 0667, reset must clear it with no done pulse
        @(negedge clk);
        io.A = 16'h9876; io.B = 16'h1234; io.bin = 1'b0; io.start = 1'b1;
        @(posedge clk);
        #1 io.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, io.ready}, 32'd1);
        chk("midrst_done",  {31'b0, io.done},  32'd0);
        chk("midrst_diff",  {16'b0, io.Diff},  32'd0);
        chk("midrst_bout",  {31'b0, io.bout},  32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (io.done) npulse++;
        end
        chk("midrst_no_done", npulse, 0);
        chk("midrst_diff_after", {16'b0, io.Diff}, 32'd0);
        run_op("after_rst", 16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 0);

        run_op("bad_digit",  16'h00A0, 16'h0000, 1'b0, 16'h00A0, 1'b0, ERR_EN, 0);
        run_op("err_clears", 16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
